// File: rtl/mod100_tens_scan_if.sv
// Units/clear inputs plus count, flag and display outputs of the tens stage of a mod-100 counter.
interface mod100_tens_scan_if;
    logic [3:0] units;
    logic       clr;
    logic [3:0] tens;
    logic [6:0] count;
    logic       carry_out;
    logic       bad_digit;
    logic [6:0] seg;
    logic [1:0] an;

    modport master (
        output units, clr,
        input  tens, count, carry_out, bad_digit, seg, an
    );

    modport slave (
        input  units, clr,
        output tens, count, carry_out, bad_digit, seg, an
    );
endinterface

// File: rtl/mod100_tens_scan.sv
// Tens stage of a MOD-100 counter: it detects the units 9->0 wrap, keeps a binary count
// and a carry pulse, and scans both digits onto a multiplexed 7-segment display.
module mod100_tens_scan #(
    parameter int unsigned SCAN_DIV = 4,
    parameter bit          BLANK_LZ = 1'b1
) (
    input logic              clk,
    input logic              rst,
    mod100_tens_scan_if.slave bus
);

    localparam logic [15:0] DIV_MAX   = 16'(SCAN_DIV - 1);
    localparam logic [6:0]  COUNT_BAD = 7'd127;

    logic [3:0]  units_q;
    logic [3:0]  tens_q, tens_d;
    logic [6:0]  count_q, count_d;
    logic        carry_q, carry_d;
    logic        bad_q, bad_d;
    logic [15:0] div_q, div_d;
    logic        sel_q, sel_d;
    logic [1:0]  an_q, an_d;
    logic [6:0]  seg_q, seg_d;
    logic        wrap;
    logic        units_bad;

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    always_comb begin
        units_bad = bus.units > 4'd9;
        wrap      = (units_q == 4'd9) && (bus.units == 4'd0);
        tens_d    = tens_q;
        carry_d   = 1'b0;
        bad_d     = bad_q | units_bad;

        // Clear takes priority over a coincident wrap.
        if (bus.clr) begin
            tens_d = 4'd0;
            bad_d  = 1'b0;
        end else if (wrap) begin
            if (tens_q == 4'd9) begin
                tens_d  = 4'd0;
                carry_d = 1'b1;
            end else begin
                tens_d = tens_q + 4'd1;
            end
        end

        count_d = units_bad ? COUNT_BAD
                            : ({3'b000, tens_d} * 7'd10) + {3'b000, bus.units};

        if (div_q == DIV_MAX) begin
            div_d = 16'd0;
            sel_d = ~sel_q;
        end else begin
            div_d = div_q + 16'd1;
            sel_d = sel_q;
        end

        // Display uses next-state values so seg/an line up with tens/count.
        an_d = sel_d ? 2'b10 : 2'b01;
        if (!sel_d) begin
            seg_d = decode(bus.units);
        end else if (BLANK_LZ && (tens_d == 4'd0)) begin
            seg_d = 7'h00;
        end else begin
            seg_d = decode(tens_d);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            units_q <= 4'd0;
            tens_q  <= 4'd0;
            count_q <= 7'd0;
            carry_q <= 1'b0;
            bad_q   <= 1'b0;
            div_q   <= 16'd0;
            sel_q   <= 1'b0;
            an_q    <= 2'b01;
            seg_q   <= 7'h3F;
        end else begin
            units_q <= bus.units;
            tens_q  <= tens_d;
            count_q <= count_d;
            carry_q <= carry_d;
            bad_q   <= bad_d;
            div_q   <= div_d;
            sel_q   <= sel_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign bus.tens      = tens_q;
    assign bus.count     = count_q;
    assign bus.carry_out = carry_q;
    assign bus.bad_digit = bad_q;
    assign bus.an        = an_q;
    assign bus.seg       = seg_q;

endmodule

// File: tb/tb_mod100_tens_scan.sv
// Bench for mod100_tens_scan: directed sequences plus random units traffic, checked
// against an arithmetic model of the MOD-100 counter and the display scan.
module tb_mod100_tens_scan;

    localparam int unsigned SCAN_DIV = 3;
    localparam bit          BLANK_LZ = 1'b1;
    localparam logic [6:0]  SEG_TAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic clk = 1'b0;
    logic rst = 1'b1;

    mod100_tens_scan_if bus ();

    mod100_tens_scan #(
        .SCAN_DIV (SCAN_DIV),
        .BLANK_LZ (BLANK_LZ)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: digits as integers, scan phase from edges since reset.
    int m_tens, m_prev, m_count, m_edges, carries;
    bit m_bad, m_carry;
    int r, u;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int d);
        return (d > 9) ? 7'h40 : SEG_TAB[d];
    endfunction

    task automatic model_reset();
        m_tens  = 0;
        m_prev  = 0;
        m_count = 0;
        m_edges = 0;
        m_bad   = 1'b0;
        m_carry = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_tens"},  32'(bus.tens), 0);
        chk({tag, "_count"}, 32'(bus.count), 0);
        chk({tag, "_carry"}, 32'(bus.carry_out), 0);
        chk({tag, "_bad"},   32'(bus.bad_digit), 0);
        chk({tag, "_an"},    32'(bus.an), 32'h1);
        chk({tag, "_seg"},   32'(bus.seg), 32'h3F);
    endtask

    task automatic step(input int uin, input bit c);
        bit          sel;
        logic [6:0]  exp_seg;
        bus.units = 4'(uin);
        bus.clr   = c;
        if (c) begin
            m_tens  = 0;
            m_bad   = 1'b0;
            m_carry = 1'b0;
        end else begin
            m_carry = 1'b0;
            if (m_prev == 9 && uin == 0) begin
                if (m_tens == 9) begin
                    m_tens  = 0;
                    m_carry = 1'b1;
                end else begin
                    m_tens++;
                end
            end
            if (uin > 9) m_bad = 1'b1;
        end
        m_prev  = uin;
        m_count = (uin > 9) ? 127 : m_tens * 10 + uin;
        m_edges++;
        @(posedge clk);
        #1;
        if (bus.carry_out === 1'b1) carries++;
        sel = ((m_edges / SCAN_DIV) % 2) == 1;
        if (!sel)                         exp_seg = seg_of(uin);
        else if (BLANK_LZ && m_tens == 0) exp_seg = 7'h00;
        else                              exp_seg = seg_of(m_tens);
        chk("tens",  32'(bus.tens), 32'(m_tens));
        chk("count", 32'(bus.count), 32'(m_count));
        chk("carry", 32'(bus.carry_out), 32'(m_carry));
        chk("bad",   32'(bus.bad_digit), 32'(m_bad));
        chk("an",    32'(bus.an), sel ? 32'h2 : 32'h1);
        chk("seg",   32'(bus.seg), 32'(exp_seg));
    endtask

    initial begin
        bus.units = 4'd0;
        bus.clr   = 1'b0;
        model_reset();
        #1 rst = 1'b0;
        #2 check_reset("reset");
        #9 rst = 1'b1;

        // Ten full units cycles: one carry, tens back to zero.
        carries = 0;
        for (int i = 1; i <= 100; i++) step(i % 10, 1'b0);
        chk("ramp_carry_pulses", 32'(carries), 1);
        chk("ramp_tens_end", 32'(bus.tens), 0);

        // Clear on the wrap edge wins over the wrap.
        for (int i = 1; i <= 35; i++) step(i % 10, 1'b0);
        step(9, 1'b0);
        step(0, 1'b1);
        chk("clr_wrap_tens", 32'(bus.tens), 0);
        chk("clr_wrap_count", 32'(bus.count), 0);

        // Illegal units value: sticky flag, dash on the units digit.
        for (int i = 0; i < 7; i++) step(12, 1'b0);
        step(3, 1'b0);
        chk("bad_sticky", 32'(bus.bad_digit), 1);
        step(5, 1'b1);
        chk("bad_cleared", 32'(bus.bad_digit), 0);
        chk("bad_clr_count", 32'(bus.count), 5);

        // tens = 4, units = 7: display alternates 07 / 66.
        step(0, 1'b1);
        for (int i = 1; i <= 40; i++) step(i % 10, 1'b0);
        for (int i = 0; i < 8; i++) step(7, 1'b0);

        // 9 then 5 is not a wrap.
        step(8, 1'b0);
        step(9, 1'b0);
        step(5, 1'b0);
        chk("jump_count", 32'(bus.count), 45);

        // Leading zero blanking with tens = 0.
        step(7, 1'b1);
        for (int i = 0; i < 6; i++) step(7, 1'b0);

        // Random traffic: mostly counting, some jumps, illegal digits and clears.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(99));
            if (r < 8)       u = int'($urandom_range(9, 0));
            else if (r < 12) u = int'($urandom_range(15, 10));
            else if (r < 30) u = int'($urandom_range(9, 0));
            else             u = (m_prev > 9) ? 0 : (m_prev + 1) % 10;
            step(u, r < 5);
        end

        // Asynchronous reset at count 57, between clock edges.
        step(0, 1'b1);
        for (int i = 1; i <= 57; i++) step(i % 10, 1'b0);
        chk("pre_reset_count", 32'(bus.count), 57);
        #2 rst = 1'b0;
        #1 check_reset("async_reset");
        #2 rst = 1'b1;
        model_reset();
        step(0, 1'b0);
        chk("post_reset_carry", 32'(bus.carry_out), 0);
        chk("post_reset_count", 32'(bus.count), 0);
        for (int i = 1; i <= 12; i++) step(i % 10, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
